cmd_frame_parser: RTL and testbench
===================================

Name: cmd_frame_parser

Overview:
Reference-clock-domain command decoder between the RX data synchronizer and the system controller. Consumes one synchronized UART byte per enable pulse and assembles multi-byte command frames:
- 0xAA register write
- 0xBB register read
- 0xCC ALU with operands
- 0xDD ALU without operands

Presents each complete frame as one decoded command with a valid/ready handshake. Reports malformed frames, overruns and stalled frames on an error strobe.

Parameters:
DATA_WIDTH, 8, width of RX byte and data/operand fields
ADDR_WIDTH, 4, register file address width; low bits of address byte
FUN_WIDTH, 4, ALU function width; low bits of function byte
TIMEOUT_CYCLES, 1024, CLK cycles allowed between bytes of one frame (compiled only with CMD_FRAME_TIMEOUT_EN)

Ports:
CLK  in  1  reference clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  synchronized received byte
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
CMD_RDY  in  1  consumer accepts command this cycle
CMD_VLD  out  1  decoded command valid; held until accepted
CMD_TYPE  out  2  00 WR, 01 RD, 10 ALU_OP, 11 ALU_NOP
CMD_ADDR  out  ADDR_WIDTH  register address (WR/RD)
CMD_DATA  out  DATA_WIDTH  write data (WR)
CMD_OPA  out  DATA_WIDTH  operand A (ALU_OP)
CMD_OPB  out  DATA_WIDTH  operand B (ALU_OP)
CMD_FUN  out  FUN_WIDTH  ALU function (ALU_OP/ALU_NOP)
ERR_VLD  out  1  one-cycle error strobe
ERR_CODE  out  2  01 bad opcode, 10 overrun, 11 timeout; valid with ERR_VLD
BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset (RST low, async): state IDLE. All outputs 0, including all field registers and the timeout counter.
- State machine and frame formats:
  - IDLE: on RX_D_VLD, decode the opcode byte.
    - 0xAA -> WR_ADDR
    - 0xBB -> RD_ADDR
    - 0xCC -> OPA
    - 0xDD -> FUN
    - any other value -> ERR_VLD=1, ERR_CODE=01 next cycle; stay IDLE.
  - WR_ADDR -> WR_DATA -> HOLD, type WR.
  - RD_ADDR -> HOLD, type RD.
  - OPA -> OPB -> FUN -> HOLD, type ALU_OP or ALU_NOP depending on the opcode.
- Field capture:
  - Each byte-collecting state advances only on RX_D_VLD and registers its field from RX_P_DATA.
  - Address and function bytes truncate to their low ADDR_WIDTH / FUN_WIDTH bits; upper bits are ignored, not checked.
- Handshake:
  - CMD_VLD rises the cycle after the RX_D_VLD of the frame's final byte (latency 1).
  - In HOLD, CMD_VLD and all CMD_* fields stay stable until a cycle with CMD_VLD & CMD_RDY. The next cycle CMD_VLD=0 and state is IDLE.
- Fields not used by a command type retain their previous values; the consumer ignores them.
- Overrun: RX_D_VLD in HOLD without CMD_RDY drops the byte and gives ERR_VLD=1, ERR_CODE=10 next cycle. The held command is unaffected.
- Simultaneous accept and byte: CMD_RDY=1 and RX_D_VLD=1 in the same HOLD cycle complete the transfer and decode the byte as an opcode exactly as in IDLE. No byte is lost; CMD_VLD is low for at least one cycle between commands.
- ERR_VLD is never asserted two consecutive cycles for one event.
- Opcode values are only recognised in IDLE. Inside a frame, 0xAA..0xDD are plain data.
- Reset mid-frame discards partial fields and any held command immediately.
- BUSY = (state != IDLE).

Optional Feature:
CMD_FRAME_TIMEOUT_EN.
- Defined:
  - A counter clears on every accepted byte and on entry to a collecting state, and increments each CLK cycle in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN.
  - When it reaches TIMEOUT_CYCLES-1 with no RX_D_VLD, the partial frame is discarded, state returns to IDLE, and ERR_VLD=1, ERR_CODE=11 next cycle.
  - RX_D_VLD on the terminal cycle wins; no timeout is raised.
  - HOLD never times out.
- Undefined: no counter is built. Collecting states wait indefinitely and ERR_CODE 11 is never produced.

Test Plan:
- Bytes AA,05,3C with CMD_RDY=1 -> one cycle with CMD_VLD=1, CMD_TYPE=00, CMD_ADDR=5, CMD_DATA=0x3C; BUSY low afterwards.
- Bytes CC,12,34,F1 with CMD_RDY=0 for 10 cycles, then 1 -> CMD_VLD held 10+1 cycles with fields stable: TYPE=10, OPA=0x12, OPB=0x34, FUN=1.
- Byte 0x55 in IDLE -> ERR_VLD pulse, ERR_CODE=01, no CMD_VLD; then BB,0x27 -> TYPE=01, ADDR=7.
- Frame DD,03 held with CMD_RDY=0, then byte 0x99 -> ERR_CODE=10 and held FUN=3 unchanged. Next: CMD_RDY=1 in the same cycle as byte 0xBB -> transfer completes and the parser enters RD_ADDR.
- With CMD_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16: bytes AA,02 then silence -> ERR_CODE=11 after 16 cycles, state IDLE. A following AA,02,44 decodes normally.
- RST pulsed low after CC,01 -> all outputs 0 asynchronously; subsequent DD,08 -> TYPE=11, FUN=8.

Source files
------------

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: assembles UART bytes into WR/RD/ALU command frames with valid/ready output and error strobe.
// Optional inter-byte frame timeout is compiled in with CMD_FRAME_TIMEOUT_EN.
module cmd_frame_parser #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  CMD_RDY,
  output logic                  CMD_VLD,
  output logic [1:0]            CMD_TYPE,
  output logic [ADDR_WIDTH-1:0] CMD_ADDR,
  output logic [DATA_WIDTH-1:0] CMD_DATA,
  output logic [DATA_WIDTH-1:0] CMD_OPA,
  output logic [DATA_WIDTH-1:0] CMD_OPB,
  output logic [FUN_WIDTH-1:0]  CMD_FUN,
  output logic                  ERR_VLD,
  output logic [1:0]            ERR_CODE,
  output logic                  BUSY
);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN, HOLD} state_t;
  state_t                state_q, state_d;
  logic [1:0]            type_q, type_d, err_code_q, err_code_d;
  logic                  err_vld_q, err_vld_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, opa_q, opa_d, opb_q, opb_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic                  start, tmo, is_aa, is_bb, is_cc, is_dd;
  assign is_aa = RX_P_DATA == DATA_WIDTH'(8'hAA);
  assign is_bb = RX_P_DATA == DATA_WIDTH'(8'hBB);
  assign is_cc = RX_P_DATA == DATA_WIDTH'(8'hCC);
  assign is_dd = RX_P_DATA == DATA_WIDTH'(8'hDD);
  // An opcode is decoded in IDLE, or in HOLD when the held command is accepted the same cycle.
  assign start = RX_D_VLD && (state_q == IDLE || (state_q == HOLD && CMD_RDY));
`ifdef CMD_FRAME_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          collecting;
  assign collecting = !(state_q inside {IDLE, HOLD});
  assign cnt_d = (!collecting || RX_D_VLD) ? '0 : cnt_q + 1'b1;
  assign tmo = collecting && !RX_D_VLD && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    type_d = type_q;
    addr_d = addr_q;
    data_d = data_q;
    opa_d = opa_q;
    opb_d = opb_q;
    fun_d = fun_q;
    err_vld_d = 1'b0;
    err_code_d = 2'b00;
    if (start) begin
      state_d = is_aa ? WR_ADDR : is_bb ? RD_ADDR : is_cc ? OPA : is_dd ? FUN : IDLE;
      type_d = is_aa ? 2'b00 : is_bb ? 2'b01 : is_cc ? 2'b10 : is_dd ? 2'b11 : type_q;
      err_vld_d = !(is_aa || is_bb || is_cc || is_dd);
      err_code_d = err_vld_d ? 2'b01 : 2'b00;
    end else if (tmo) begin
      state_d = IDLE;
      err_vld_d = 1'b1;
      err_code_d = 2'b11;
    end else if (RX_D_VLD) begin
      case (state_q)
        WR_ADDR: begin addr_d = RX_P_DATA[ADDR_WIDTH-1:0]; state_d = WR_DATA; end
        WR_DATA: begin data_d = RX_P_DATA; state_d = HOLD; end
        RD_ADDR: begin addr_d = RX_P_DATA[ADDR_WIDTH-1:0]; state_d = HOLD; end
        OPA:     begin opa_d = RX_P_DATA; state_d = OPB; end
        OPB:     begin opb_d = RX_P_DATA; state_d = FUN; end
        FUN:     begin fun_d = RX_P_DATA[FUN_WIDTH-1:0]; state_d = HOLD; end
        HOLD:    begin err_vld_d = 1'b1; err_code_d = 2'b10; end
        default: state_d = IDLE;
      endcase
    end else if (state_q == HOLD && CMD_RDY) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      type_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      fun_q <= '0;
      err_vld_q <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      addr_q <= addr_d;
      data_q <= data_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      fun_q <= fun_d;
      err_vld_q <= err_vld_d;
      err_code_q <= err_code_d;
    end
  assign CMD_VLD = state_q == HOLD;
  assign BUSY = state_q != IDLE;
  assign CMD_TYPE = type_q;
  assign CMD_ADDR = addr_q;
  assign CMD_DATA = data_q;
  assign CMD_OPA = opa_q;
  assign CMD_OPB = opb_q;
  assign CMD_FUN = fun_q;
  assign ERR_VLD = err_vld_q;
  assign ERR_CODE = err_code_q;
endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser: directed-vector bench for cmd_frame_parser (timeout scenario when CMD_FRAME_TIMEOUT_EN is defined).
module tb_cmd_frame_parser;
  logic       CLK = 1'b0, RST = 1'b0, RX_D_VLD = 1'b0, CMD_RDY = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       CMD_VLD, ERR_VLD, BUSY;
  logic [1:0] CMD_TYPE, ERR_CODE;
  logic [3:0] CMD_ADDR, CMD_FUN;
  logic [7:0] CMD_DATA, CMD_OPA, CMD_OPB;
  int n_checks = 0, n_fail = 0;
  cmd_frame_parser #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .CMD_RDY(CMD_RDY),
    .CMD_VLD(CMD_VLD), .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .CMD_OPA(CMD_OPA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN), .ERR_VLD(ERR_VLD),
    .ERR_CODE(ERR_CODE), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  // Called at a negedge; the byte is captured on the next posedge and the call returns at the following negedge.
  task automatic put(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD = 1'b1;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
  endtask
  task automatic test_reset;
    logic [48:0] got;
    #3;
    got = {CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPA, CMD_OPB, CMD_FUN, ERR_VLD, ERR_CODE, BUSY};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", got); end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask
  task automatic test_write;
    CMD_RDY = 1'b1;
    put(8'hAA); put(8'h05); put(8'h3C);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, BUSY} !== {1'b1, 2'b00, 4'h5, 8'h3C, 1'b1}) begin
      n_fail++;
      $display("FAIL write_cmd got vld=%b type=%b addr=%h data=%h busy=%b exp 1/00/5/3c/1", CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, BUSY);
    end
    @(negedge CLK);
    n_checks++;
    if ({CMD_VLD, BUSY, ERR_VLD} !== 3'b000) begin n_fail++; $display("FAIL write_after got vld/busy/err=%b exp 000", {CMD_VLD, BUSY, ERR_VLD}); end
  endtask
  task automatic test_hold;
    CMD_RDY = 1'b0;
    put(8'hCC); put(8'h12); put(8'h34); put(8'hF1);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) CMD_RDY = 1'b1;
      n_checks++;
      if ({CMD_VLD, CMD_TYPE, CMD_OPA, CMD_OPB, CMD_FUN} !== {1'b1, 2'b10, 8'h12, 8'h34, 4'h1}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got vld=%b type=%b opa=%h opb=%h fun=%h exp 1/10/12/34/1", i, CMD_VLD, CMD_TYPE, CMD_OPA, CMD_OPB, CMD_FUN);
      end
      @(negedge CLK);
    end
    n_checks++;
    if ({CMD_VLD, BUSY} !== 2'b00) begin n_fail++; $display("FAIL hold_release got vld/busy=%b exp 00", {CMD_VLD, BUSY}); end
  endtask
  task automatic test_bad_opcode;
    CMD_RDY = 1'b1;
    put(8'h55);
    n_checks++;
    if ({ERR_VLD, ERR_CODE, CMD_VLD, BUSY} !== {1'b1, 2'b01, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL bad_opcode got err=%b code=%b vld=%b busy=%b exp 1/01/0/0", ERR_VLD, ERR_CODE, CMD_VLD, BUSY);
    end
    @(negedge CLK);
    n_checks++;
    if (ERR_VLD !== 1'b0) begin n_fail++; $display("FAIL bad_opcode_single got err=%b exp 0", ERR_VLD); end
    put(8'hBB); put(8'h27);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_ADDR} !== {1'b1, 2'b01, 4'h7}) begin
      n_fail++;
      $display("FAIL read_cmd got vld=%b type=%b addr=%h exp 1/01/7", CMD_VLD, CMD_TYPE, CMD_ADDR);
    end
    @(negedge CLK);
  endtask
  task automatic test_overrun_back_to_back;
    CMD_RDY = 1'b0;
    put(8'hDD); put(8'h03);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_FUN} !== {1'b1, 2'b11, 4'h3}) begin
      n_fail++;
      $display("FAIL nop_cmd got vld=%b type=%b fun=%h exp 1/11/3", CMD_VLD, CMD_TYPE, CMD_FUN);
    end
    put(8'h99);
    n_checks++;
    if ({ERR_VLD, ERR_CODE, CMD_VLD, CMD_TYPE, CMD_FUN} !== {1'b1, 2'b10, 1'b1, 2'b11, 4'h3}) begin
      n_fail++;
      $display("FAIL overrun got err=%b code=%b vld=%b type=%b fun=%h exp 1/10/1/11/3", ERR_VLD, ERR_CODE, CMD_VLD, CMD_TYPE, CMD_FUN);
    end
    @(negedge CLK);
    n_checks++;
    if ({ERR_VLD, CMD_VLD} !== 2'b01) begin n_fail++; $display("FAIL overrun_single got err/vld=%b exp 01", {ERR_VLD, CMD_VLD}); end
    CMD_RDY = 1'b1;
    put(8'hBB);
    n_checks++;
    if ({CMD_VLD, BUSY, ERR_VLD} !== 3'b010) begin n_fail++; $display("FAIL accept_and_opcode got vld/busy/err=%b exp 010", {CMD_VLD, BUSY, ERR_VLD}); end
    put(8'h0A);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_ADDR} !== {1'b1, 2'b01, 4'hA}) begin
      n_fail++;
      $display("FAIL b2b_read got vld=%b type=%b addr=%h exp 1/01/a", CMD_VLD, CMD_TYPE, CMD_ADDR);
    end
    @(negedge CLK);
  endtask
  task automatic test_opcodes_as_data;
    CMD_RDY = 1'b1;
    put(8'hAA); put(8'hBB); put(8'hCC);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, ERR_VLD} !== {1'b1, 2'b00, 4'hB, 8'hCC, 1'b0}) begin
      n_fail++;
      $display("FAIL data_opcodes got vld=%b type=%b addr=%h data=%h err=%b exp 1/00/b/cc/0", CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, ERR_VLD);
    end
    @(negedge CLK);
    put(8'hDD); put(8'hF7);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_FUN} !== {1'b1, 2'b11, 4'h7}) begin
      n_fail++;
      $display("FAIL fun_trunc got vld=%b type=%b fun=%h exp 1/11/7", CMD_VLD, CMD_TYPE, CMD_FUN);
    end
    @(negedge CLK);
  endtask
`ifdef CMD_FRAME_TIMEOUT_EN
  task automatic test_timeout;
    CMD_RDY = 1'b1;
    put(8'hAA); put(8'h02);
    repeat (15) @(negedge CLK);
    n_checks++;
    if ({BUSY, ERR_VLD} !== 2'b10) begin n_fail++; $display("FAIL timeout_early got busy/err=%b exp 10", {BUSY, ERR_VLD}); end
    @(negedge CLK);
    n_checks++;
    if ({ERR_VLD, ERR_CODE, BUSY, CMD_VLD} !== {1'b1, 2'b11, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout got err=%b code=%b busy=%b vld=%b exp 1/11/0/0", ERR_VLD, ERR_CODE, BUSY, CMD_VLD);
    end
    @(negedge CLK);
    put(8'hAA);
    repeat (15) @(negedge CLK);
    put(8'h02);
    n_checks++;
    if ({BUSY, ERR_VLD} !== 2'b10) begin n_fail++; $display("FAIL timeout_terminal_byte got busy/err=%b exp 10", {BUSY, ERR_VLD}); end
    put(8'h44);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA} !== {1'b1, 2'b00, 4'h2, 8'h44}) begin
      n_fail++;
      $display("FAIL timeout_recover got vld=%b type=%b addr=%h data=%h exp 1/00/2/44", CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA);
    end
    @(negedge CLK);
  endtask
`else
  task automatic test_timeout;
    CMD_RDY = 1'b1;
    put(8'hAA); put(8'h02);
    repeat (40) @(negedge CLK);
    n_checks++;
    if ({BUSY, ERR_VLD, CMD_VLD} !== 3'b100) begin n_fail++; $display("FAIL no_timeout got busy/err/vld=%b exp 100", {BUSY, ERR_VLD, CMD_VLD}); end
    put(8'h44);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA} !== {1'b1, 2'b00, 4'h2, 8'h44}) begin
      n_fail++;
      $display("FAIL late_byte got vld=%b type=%b addr=%h data=%h exp 1/00/2/44", CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA);
    end
    @(negedge CLK);
  endtask
`endif
  task automatic test_async_reset;
    logic [48:0] got;
    CMD_RDY = 1'b0;
    put(8'hCC); put(8'h01);
    n_checks++;
    if ({BUSY, CMD_OPA} !== {1'b1, 8'h01}) begin n_fail++; $display("FAIL pre_reset got busy=%b opa=%h exp 1/01", BUSY, CMD_OPA); end
    #2 RST = 1'b0;
    #1;
    got = {CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_DATA, CMD_OPA, CMD_OPB, CMD_FUN, ERR_VLD, ERR_CODE, BUSY};
    n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", got); end
    @(negedge CLK);
    RST = 1'b1;
    CMD_RDY = 1'b1;
    @(negedge CLK);
    put(8'hDD); put(8'h08);
    n_checks++;
    if ({CMD_VLD, CMD_TYPE, CMD_FUN, CMD_OPA} !== {1'b1, 2'b11, 4'h8, 8'h00}) begin
      n_fail++;
      $display("FAIL post_reset got vld=%b type=%b fun=%h opa=%h exp 1/11/8/00", CMD_VLD, CMD_TYPE, CMD_FUN, CMD_OPA);
    end
    @(negedge CLK);
  endtask
  initial begin
    test_reset;
    test_write;
    test_hold;
    test_bad_opcode;
    test_overrun_back_to_back;
    test_opcodes_as_data;
    test_timeout;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
